// File: rtl/mem_req_arbiter.sv
// Memory-side request arbiter for the dcache/icache request protocol.
// Picks one request per cycle for main memory, returns the accept to the
// winner, records which cache owns each outstanding load tag and routes
// tagged response blocks back to the owning cache one cycle later.
module mem_req_arbiter #(
  parameter int TAG_BITS     = 4,
  parameter int ADDR_BITS    = 32,
  parameter int BLOCK_BITS   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_req_valid,
  input  logic [1:0]            d_req_cmd,
  input  logic [ADDR_BITS-1:0]  d_req_addr,
  input  logic [BLOCK_BITS-1:0] d_req_data,
  output logic                  d_req_accepted,
  input  logic                  i_req_valid,
  input  logic [1:0]            i_req_cmd,
  input  logic [ADDR_BITS-1:0]  i_req_addr,
  output logic                  i_req_accepted,
  output logic [1:0]            mem_cmd,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [BLOCK_BITS-1:0] mem_data,
  input  logic [TAG_BITS-1:0]   mem_req_tag,
  input  logic [BLOCK_BITS-1:0] mem_resp_data,
  input  logic [TAG_BITS-1:0]   mem_resp_tag,
  output logic                  d_resp_valid,
  output logic                  i_resp_valid,
  output logic [BLOCK_BITS-1:0] resp_data,
  output logic [TAG_BITS-1:0]   resp_tag,
  output logic                  protocol_error
);
  localparam int ENTRIES = 1 << TAG_BITS;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {WIN_NONE, WIN_D, WIN_I} win_e;

  win_e                 win;
  logic                 d_req, i_req, starved, tag_ok;
  logic                 accept, alloc, resp_hit, resp_own, dbl_alloc;
  logic [CNT_W-1:0]     starve_cnt;
  logic [ENTRIES-1:0]   tbl_vld;   // entry holds an outstanding load
  logic [ENTRIES-1:0]   tbl_own;   // 0 = dcache, 1 = icache

  // Only load/store from the dcache and load from the icache count as requests.
  assign d_req   = d_req_valid && (d_req_cmd == CMD_LOAD || d_req_cmd == CMD_STORE);
  assign i_req   = i_req_valid && (i_req_cmd == CMD_LOAD);
  assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign tag_ok  = (mem_req_tag != '0);

  // Winner select and memory command mux; nothing issues while in reset.
  always_comb begin
    win      = WIN_NONE;
    mem_cmd  = CMD_NONE;
    mem_addr = '0;
    mem_data = '0;
    if (i_req && (starved || !d_req))
      win = WIN_I;
    else if (d_req)
      win = WIN_D;
    if (win == WIN_D) begin
      mem_cmd  = d_req_cmd;
      mem_addr = d_req_addr;
      mem_data = d_req_data;
    end else if (win == WIN_I) begin
      mem_cmd  = CMD_LOAD;
      mem_addr = i_req_addr;
    end
    if (!reset)
      mem_cmd = CMD_NONE;
  end

  assign d_req_accepted = reset && (win == WIN_D) && tag_ok;
  assign i_req_accepted = reset && (win == WIN_I) && tag_ok;
  assign accept         = d_req_accepted || i_req_accepted;
  assign alloc          = accept && (mem_cmd == CMD_LOAD);

  // Lookup uses pre-edge table; a same-tag free masks the double-alloc error.
  assign resp_hit  = (mem_resp_tag != '0) && tbl_vld[mem_resp_tag];
  assign resp_own  = tbl_own[mem_resp_tag];
  assign dbl_alloc = alloc && tbl_vld[mem_req_tag] &&
                     !(resp_hit && (mem_resp_tag == mem_req_tag));

  // Owner table: free first, allocate last so a same-tag allocate wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tbl_vld <= '0;
      tbl_own <= '0;
    end else begin
      if (resp_hit)
        tbl_vld[mem_resp_tag] <= 1'b0;
      if (alloc) begin
        tbl_vld[mem_req_tag] <= 1'b1;
        tbl_own[mem_req_tag] <= i_req_accepted;
      end
    end
  end

  // Registered response routing; data/tag hold between responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_resp_valid <= 1'b0;
      i_resp_valid <= 1'b0;
      resp_data    <= '0;
      resp_tag     <= '0;
    end else begin
      d_resp_valid <= resp_hit && !resp_own;
      i_resp_valid <= resp_hit && resp_own;
      if (resp_hit) begin
        resp_data <= mem_resp_data;
        resp_tag  <= mem_resp_tag;
      end
    end
  end

  // Sticky error on allocation into a live entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      protocol_error <= 1'b0;
    else if (dbl_alloc)
      protocol_error <= 1'b1;
  end

  // Counts consecutive icache wait cycles, saturating at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (!i_req_valid || i_req_accepted)
      starve_cnt <= '0;
    else if (!starved)
      starve_cnt <= starve_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: the driver evaluates a reference
// model each cycle and queues expected outputs; a negedge monitor compares.
module tb_mem_req_arbiter;
  localparam int LIMIT = 4;

  logic        clock, reset;
  logic        d_req_valid, i_req_valid;
  logic [1:0]  d_req_cmd, i_req_cmd;
  logic [31:0] d_req_addr, i_req_addr;
  logic [63:0] d_req_data;
  logic        d_req_accepted, i_req_accepted;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic [3:0]  mem_req_tag, mem_resp_tag;
  logic [63:0] mem_resp_data;
  logic        d_resp_valid, i_resp_valid;
  logic [63:0] resp_data;
  logic [3:0]  resp_tag;
  logic        protocol_error;

  mem_req_arbiter #(.TAG_BITS(4), .ADDR_BITS(32), .BLOCK_BITS(64), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd), .d_req_addr(d_req_addr),
    .d_req_data(d_req_data), .d_req_accepted(d_req_accepted),
    .i_req_valid(i_req_valid), .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr),
    .i_req_accepted(i_req_accepted),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_req_tag(mem_req_tag), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
    .d_resp_valid(d_resp_valid), .i_resp_valid(i_resp_valid),
    .resp_data(resp_data), .resp_tag(resp_tag), .protocol_error(protocol_error)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          chk_ad;
    bit          da, ia;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
  } comb_t;

  typedef struct {
    int          due;
    bit          dv, iv, err;
    logic [63:0] data;
    logic [3:0]  tag;
  } resp_t;

  comb_t comb_q[$];
  resp_t resp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state: owner per outstanding load tag (0 = d, 1 = i).
  bit own[int];
  int scnt = 0;
  bit err  = 0;

  // Monitor: compare whatever the DUT shows against due expectations.
  always @(negedge clock) begin
    while (comb_q.size() > 0 && comb_q[0].due <= cyc) begin
      comb_t c;
      c = comb_q.pop_front();
      chk("d_req_accepted", d_req_accepted, c.da);
      chk("i_req_accepted", i_req_accepted, c.ia);
      chk("mem_cmd", mem_cmd, c.cmd);
      if (c.chk_ad) begin
        chk("mem_addr", mem_addr, c.addr);
        chk("mem_data", mem_data, c.data);
      end
    end
    while (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      resp_t r;
      r = resp_q.pop_front();
      if (!reset) begin
        r.dv = 0; r.iv = 0; r.err = 0; r.data = '0; r.tag = '0;
        chk("resp_data_rst", resp_data, r.data);
        chk("resp_tag_rst", resp_tag, r.tag);
      end
      chk("d_resp_valid", d_resp_valid, r.dv);
      chk("i_resp_valid", i_resp_valid, r.iv);
      chk("protocol_error", protocol_error, r.err);
      if (r.dv || r.iv) begin
        chk("resp_data", resp_data, r.data);
        chk("resp_tag", resp_tag, r.tag);
      end
    end
  end

  // Evaluate the model for the inputs currently driven, queue expectations,
  // then advance one clock.
  task automatic step();
    comb_t c;
    resp_t r;
    bit dq, iq, ok, is_load;
    int w;
    dq = d_req_valid && (d_req_cmd == 2'd1 || d_req_cmd == 2'd2);
    iq = i_req_valid && (i_req_cmd == 2'd1);
    ok = (mem_req_tag != 0);
    w  = 0;
    if (reset) begin
      if (iq && (scnt >= LIMIT || !dq)) w = 2;
      else if (dq) w = 1;
    end
    c.due    = cyc;
    c.chk_ad = reset;
    c.da     = (w == 1) && ok;
    c.ia     = (w == 2) && ok;
    c.cmd    = (w == 1) ? d_req_cmd : (w == 2) ? 2'd1 : 2'd0;
    c.addr   = (w == 1) ? d_req_addr : (w == 2) ? i_req_addr : 32'd0;
    c.data   = (w == 1) ? d_req_data : 64'd0;
    comb_q.push_back(c);

    r.due = cyc + 1; r.dv = 0; r.iv = 0; r.data = '0; r.tag = '0;
    if (!reset) begin
      own.delete();
      scnt = 0;
      err  = 0;
    end else begin
      if (mem_resp_tag != 0 && own.exists(int'(mem_resp_tag))) begin
        r.dv   = (own[int'(mem_resp_tag)] == 0);
        r.iv   = (own[int'(mem_resp_tag)] == 1);
        r.data = mem_resp_data;
        r.tag  = mem_resp_tag;
        own.delete(int'(mem_resp_tag));
      end
      is_load = (c.cmd == 2'd1);
      if ((c.da || c.ia) && is_load) begin
        if (own.exists(int'(mem_req_tag))) err = 1;
        own[int'(mem_req_tag)] = c.ia;
      end
      if (!i_req_valid || c.ia) scnt = 0;
      else if (scnt < LIMIT) scnt++;
    end
    r.err = err;
    resp_q.push_back(r);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    d_req_valid = 0; d_req_cmd = 0; d_req_addr = 0; d_req_data = 0;
    i_req_valid = 0; i_req_cmd = 0; i_req_addr = 0;
    mem_req_tag = 0; mem_resp_tag = 0; mem_resp_data = 0;
  endtask

  task automatic d_load(input logic [31:0] a, input logic [3:0] t);
    d_req_valid = 1; d_req_cmd = 2'd1; d_req_addr = a; mem_req_tag = t;
  endtask

  initial begin
    idle();
    reset = 0;
    step();
    step();
    reset = 1;
    idle(); step();

    // Single dcache load, tag 3, then its response
    d_load(32'h100, 4'd3); step();
    idle(); mem_resp_tag = 4'd3; mem_resp_data = 64'hDEAD; step();
    idle(); step();

    // Starvation: both request continuously with fresh tags
    for (int k = 0; k < 10; k++) begin
      d_load($urandom, 4'(5 + k));
      i_req_valid = 1; i_req_cmd = 2'd1; i_req_addr = $urandom;
      step();
    end
    idle();
    // Return tags 5..14 back to back
    for (int t = 5; t < 15; t++) begin
      mem_resp_tag = 4'(t); mem_resp_data = {$urandom, $urandom}; step();
    end
    idle(); step();

    // Rejection: three tag-0 cycles, then tag 9
    for (int k = 0; k < 3; k++) begin d_load(32'h200, 4'd0); step(); end
    d_load(32'h200, 4'd9); step();
    idle(); mem_resp_tag = 4'd9; mem_resp_data = 64'h99; step();

    // Store completion is dropped silently
    idle(); d_req_valid = 1; d_req_cmd = 2'd2; d_req_addr = 32'h300;
    d_req_data = 64'hCAFE; mem_req_tag = 4'd2; step();
    idle(); mem_resp_tag = 4'd2; mem_resp_data = 64'h1234; step();
    idle(); step();

    // Same-cycle free and reallocate of tag 4
    i_req_valid = 1; i_req_cmd = 2'd1; i_req_addr = 32'h400; mem_req_tag = 4'd4; step();
    idle(); d_load(32'h500, 4'd4); mem_resp_tag = 4'd4; mem_resp_data = 64'hAAAA; step();
    idle(); step();
    mem_resp_tag = 4'd4; mem_resp_data = 64'hBBBB; step();
    idle(); step();

    // Reset with three loads outstanding
    for (int t = 1; t < 4; t++) begin d_load(32'h600 + t, 4'(t)); step(); end
    idle(); mem_resp_tag = 4'd1; mem_resp_data = 64'h11;
    reset = 0; step();
    reset = 1;
    for (int t = 1; t < 4; t++) begin
      idle(); mem_resp_tag = 4'(t); mem_resp_data = 64'(t); step();
    end
    idle(); step();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      d_req_valid   = 1'($urandom_range(0, 1));
      d_req_cmd     = 2'($urandom_range(0, 3));
      d_req_addr    = $urandom;
      d_req_data    = {$urandom, $urandom};
      i_req_valid   = ($urandom_range(0, 3) != 0);
      i_req_cmd     = ($urandom_range(0, 5) == 0) ? 2'd2 : 2'd1;
      i_req_addr    = $urandom;
      mem_req_tag   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem_resp_tag  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem_resp_data = {$urandom, $urandom};
      reset         = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1;
    idle(); step(); step();
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Memory-side responder for the cache request protocol. It accepts load and store requests from the dcache and the icache, and forwards one request per cycle to main memory. It returns the per-cycle accept handshake to the winning requester. It tracks which requester owns each outstanding memory tag and routes the tagged response block back to the correct cache. It sits between the two cache subsystems and `mem`.

## Interface

**Parameters**
- `TAG_BITS`, default 4: memory tag width. Tag 0 means "no tag / rejected".
- `ADDR_BITS`, default 32: request address width.
- `BLOCK_BITS`, default 64: memory block width.
- `STARVE_LIMIT`, default 4: consecutive icache wait cycles before the icache is forced to win.

**Ports** (all widths unsigned)
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low. When `reset` = 0, all state clears immediately.
- `d_req_valid`, in, 1: dcache request present.
- `d_req_cmd`, in, 2: 1 = load, 2 = store. 0 and 3 are treated as no request.
- `d_req_addr`, in, `ADDR_BITS`: dcache request address.
- `d_req_data`, in, `BLOCK_BITS`: dcache store data.
- `d_req_accepted`, out, 1: dcache request taken by memory this cycle.
- `i_req_valid`, `i_req_cmd`, `i_req_addr`: in, same widths as the dcache request. The icache issues loads only; an icache store is treated as no request.
- `i_req_accepted`, out, 1: icache request taken this cycle.
- `mem_cmd`, out, 2: command to memory (0 = none, 1 = load, 2 = store).
- `mem_addr`, out, `ADDR_BITS`: address to memory.
- `mem_data`, out, `BLOCK_BITS`: store data to memory.
- `mem_req_tag`, in, `TAG_BITS`: tag memory assigns to the current command. Nonzero means accepted. Arrives combinationally in the same cycle.
- `mem_resp_data`, in, `BLOCK_BITS`: returning block.
- `mem_resp_tag`, in, `TAG_BITS`: tag of the returning block. 0 means no response.
- `d_resp_valid`, `i_resp_valid`, out, 1 each: registered response strobe for that cache.
- `resp_data`, out, `BLOCK_BITS`: registered response block, shared by both caches.
- `resp_tag`, out, `TAG_BITS`: registered response tag.
- `protocol_error`, out, 1: sticky error flag.

## Operation

**Arbitration (combinational)**
- Default winner is the dcache when both caches request.
- The icache wins instead when `starve_cnt` ≥ `STARVE_LIMIT` and `i_req_valid` is 1.
- The winner's cmd, addr and data drive `mem_*`. With no valid request, `mem_cmd` = 0 and `mem_addr` and `mem_data` = 0.
- `X_req_accepted` = (X is the winner) AND (`mem_req_tag` ≠ 0). At most one accept is high per cycle.
- If `mem_req_tag` = 0, nothing is accepted and no state changes for that request; the requester holds and retries.

**Owner table**
- `2^TAG_BITS` entries, each holding `{valid, owner}` with owner 0 = dcache, 1 = icache. Entry 0 is never used.
- Allocation: an accepted **load** writes `table[mem_req_tag]` ← `{1, winner}`. Accepted stores allocate nothing.
- Double allocation: if the entry is already valid and not being freed in the same cycle, set `protocol_error`. The new owner still overwrites the entry.

**Response routing**
- When `mem_resp_tag` ≠ 0, look up `table[mem_resp_tag]` using the pre-edge table contents.
- Entry valid: on the next edge, `resp_data` ← `mem_resp_data`, `resp_tag` ← `mem_resp_tag`, and the owner's `*_resp_valid` ← 1 for exactly one cycle. The entry is cleared.
- Entry invalid: the response is dropped (this covers store completions) and no error is raised.

**Simultaneous free and allocate**
- Free and allocate can hit the same tag in one cycle. The response is routed to the old owner, and the entry ends the cycle holding the new allocation.

**Starvation counter**
- `starve_cnt` has `$clog2(STARVE_LIMIT+1)` bits and saturates at `STARVE_LIMIT`.
- It increments when `i_req_valid` = 1 and `i_req_accepted` = 0.
- It clears when `i_req_accepted` = 1 or `i_req_valid` = 0.

## Timing

- Request to accept: 0 cycles (combinational through `mem_req_tag`).
- Response tag to `*_resp_valid`: 1 cycle, registered.
- Back-to-back responses produce strobes on consecutive cycles with no bubble.
- Reset values: `d_resp_valid` and `i_resp_valid` = 0, `resp_data` = 0, `resp_tag` = 0, `protocol_error` = 0, all table entries invalid, `starve_cnt` = 0.
- While `reset` = 0:
  - `mem_cmd` is forced to 0 and both accepts are forced to 0.
  - Responses arriving during reset are discarded.
  - Outstanding ownership is lost; later responses for those tags are dropped.

## Test plan

- **Single dcache load:** dcache load at addr 0x100 with `mem_req_tag` = 3. Expect `d_req_accepted` = 1 in the same cycle and `table[3]` = dcache. Then return tag 3 with data 0xDEAD. Expect `d_resp_valid` = 1 one cycle later, `resp_data` = 0xDEAD, `resp_tag` = 3, and `i_resp_valid` = 0.
- **Starvation:** both caches request continuously with `mem_req_tag` = 5, 6, 7, ….
  - Expect the dcache to be accepted in cycles 0–3 and the icache in cycle 4.
  - Expect `starve_cnt` to read 0 after the icache accept.
- **Rejection:** dcache load with `mem_req_tag` = 0 for 3 cycles, then 9.
  - Expect no accept and no table change for the 3 rejected cycles.
  - Expect the accept in the 4th cycle, with `table[9]` valid.
- **Store completion:** dcache store accepted with tag 2, then `mem_resp_tag` = 2. Expect no `*_resp_valid` pulse and `protocol_error` = 0.
- **Same-cycle free and reallocate:** icache owns tag 4. In one cycle, `mem_resp_tag` = 4 arrives and a dcache load is accepted with tag 4.
  - Expect `i_resp_valid` = 1 next cycle.
  - Expect `table[4]` = dcache.
  - A later tag-4 response must pulse `d_resp_valid`.
- **Reset mid-flight:** 3 loads outstanding (tags 1, 2, 3), pull `reset` low for 1 cycle, then return tags 1–3.
  - Expect all outputs at their reset values while `reset` = 0.
  - Expect no response strobes after reset is released.
  - Expect `protocol_error` = 0.
